gate_truth_checker: RTL

- Self-sequencing truth-table checker for small combinational gates in the basic-gates library.
- Sits on both sides of a gate under test. Upstream, it drives every input vector to the gate in ascending order. Downstream, it samples the gate's output after a programmable settle time.
- Compares each sample against a parameterised expected truth table and reports pass/fail, the mismatch count and the first failing vector.
- Replaces hand-written stimulus lists with one reusable synthesizable checker.

---
 rtl/gate_truth_checker.sv | 93 +++++++++
 1 files changed

// File: rtl/gate_truth_checker.sv
// Walks all 2**N_IN input vectors into a gate, samples its output SETTLE cycles later and checks it against EXPECTED.
// Latency: (2**N_IN)*(SETTLE+1) cycles from start to done; no backpressure, start is ignored while a run is active.
module gate_truth_checker #(
  parameter int                   N_IN     = 2,
  parameter int                   SETTLE   = 2,
  parameter logic [(1<<N_IN)-1:0] EXPECTED = 4'b1000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [N_IN-1:0] vec,
  input  logic            dut_y,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] first_fail_vec,
  output logic            fail_seen
);

  localparam int              CW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(SETTLE - 1);
  localparam logic [N_IN-1:0] VEC_LAST = '1;

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic            mismatch;
  logic [N_IN:0]   err_nxt;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = DRIVE;
      DRIVE:   if (cnt == CNT_LAST) state_nxt = SAMPLE;
      SAMPLE:  state_nxt = (vec == VEC_LAST) ? DONE : DRIVE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy     = (state == DRIVE) || (state == SAMPLE);
  assign done     = (state == DONE);
  assign mismatch = (dut_y != EXPECTED[vec]);
  assign err_nxt  = err_count + (N_IN+1)'(mismatch);

  // pass is decided from the count including the final sample so it lines up with done
  always_ff @(posedge clk) begin
    if (rst) begin
      vec            <= '0;
      cnt            <= '0;
      err_count      <= '0;
      first_fail_vec <= '0;
      fail_seen      <= 1'b0;
      pass           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            vec            <= '0;
            cnt            <= '0;
            err_count      <= '0;
            first_fail_vec <= '0;
            fail_seen      <= 1'b0;
            pass           <= 1'b0;
          end
        end
        DRIVE: begin
          if (cnt == CNT_LAST) cnt <= '0;
          else                 cnt <= cnt + CW'(1);
        end
        SAMPLE: begin
          err_count <= err_nxt;
          if (mismatch && !fail_seen) begin
            first_fail_vec <= vec;
            fail_seen      <= 1'b1;
          end
          if (vec == VEC_LAST) pass <= (err_nxt == '0);
          else                 vec  <= vec + N_IN'(1);
        end
        DONE:    vec <= '0;
        default: vec <= '0;
      endcase
    end
  end

endmodule
